alu_issue_ctrl: RTL and testbench

Upstream control stage for the 8-bit ALU. Accepts ALU commands over a valid/ready handshake and reads operands from a small internal register file. Drives the ALU operand, select and latch inputs, then writes the ALU result and carry back into the register file. Illegal opcodes, divide-by-zero and a missing update response are caught before they can corrupt state.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_regfile.sv | 56 +++++
 rtl/alu_issue_ctrl.sv | 141 ++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller:
// opcodes, error codes and controller states.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_MUL  = 4'd2;
    localparam logic [3:0] OP_DIV  = 4'd3;
    localparam logic [3:0] OP_SHL  = 4'd4;
    localparam logic [3:0] OP_SHR  = 4'd5;
    localparam logic [3:0] OP_SQA  = 4'd6;
    localparam logic [3:0] OP_SQB  = 4'd7;
    localparam logic [3:0] OP_LAST = 4'd7;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_DIV0    = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DONE,
        S_ERR
    } state_t;

    function automatic logic op_legal(input logic [3:0] op);
        return op <= OP_LAST;
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// Operand register file: two operand reads, a debug read
// and one write port shared between host and writeback.
module alu_regfile
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREGS = 4,
    parameter int RAW   = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [RAW-1:0]   ra_addr,
    output logic [WIDTH-1:0] ra_data,
    input  logic [RAW-1:0]   rb_addr,
    output logic [WIDTH-1:0] rb_data,
    input  logic [RAW-1:0]   dbg_addr,
    output logic [WIDTH-1:0] dbg_data,
    input  logic             host_en,
    input  logic [RAW-1:0]   host_addr,
    input  logic [WIDTH-1:0] host_data,
    input  logic             wb_sel,
    input  logic             wb_en,
    input  logic [RAW-1:0]   wb_addr,
    input  logic [WIDTH-1:0] wb_data
);

    logic [WIDTH-1:0] regs [NREGS];
    logic             we;
    logic [RAW-1:0]   waddr;
    logic [WIDTH-1:0] wdata;

    always_comb begin
        we    = host_en;
        waddr = host_addr;
        wdata = host_data;
        if (wb_sel) begin
            we    = wb_en;
            waddr = wb_addr;
            wdata = wb_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign ra_data  = regs[ra_addr];
    assign rb_data  = regs[rb_addr];
    assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller in front of the 8-bit ALU:
// captures operands, waits for the ALU update, writes back.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int NREGS    = 4,
    parameter int WAIT_MAX = 4,
    parameter int RAW      = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [RAW-1:0]   cmd_src_a,
    input  logic [RAW-1:0]   cmd_src_b,
    input  logic [RAW-1:0]   cmd_dst,
    input  logic             wr_en,
    input  logic [RAW-1:0]   wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [RAW-1:0]   rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_sel,
    output logic             alu_latch,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_carry,
    input  logic             alu_update,
    output logic             carry_flag,
    output logic             done,
    output logic             err,
    output logic [1:0]       err_code
);

    localparam int CW = $clog2(WAIT_MAX + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_MAX - 1);

    state_t           state;
    logic [RAW-1:0]   dst;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] ra_data;
    logic [WIDTH-1:0] rb_data;
    logic             in_idle;
    logic             in_issue;
    logic             accept;
    logic             wb_en;

    assign in_idle   = (state == S_IDLE);
    assign in_issue  = (state == S_ISSUE);
    assign cmd_ready = in_idle;
    assign accept    = cmd_valid && in_idle;
    assign wb_en     = in_issue && alu_update;

    alu_regfile #(
        .WIDTH (WIDTH),
        .NREGS (NREGS),
        .RAW   (RAW)
    ) u_rf (
        .clk       (clk),
        .reset     (reset),
        .ra_addr   (cmd_src_a),
        .ra_data   (ra_data),
        .rb_addr   (cmd_src_b),
        .rb_data   (rb_data),
        .dbg_addr  (rd_addr),
        .dbg_data  (rd_data),
        .host_en   (wr_en && in_idle),
        .host_addr (wr_addr),
        .host_data (wr_data),
        .wb_sel    (in_issue),
        .wb_en     (wb_en),
        .wb_addr   (dst),
        .wb_data   (alu_out)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_sel    <= '0;
            alu_latch  <= 1'b0;
            dst        <= '0;
            cnt        <= '0;
            carry_flag <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            err_code   <= ERR_NONE;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        alu_a    <= ra_data;
                        alu_b    <= rb_data;
                        alu_sel  <= cmd_op;
                        dst      <= cmd_dst;
                        cnt      <= '0;
                        err_code <= ERR_NONE;
                        if (!op_legal(cmd_op)) begin
                            state    <= S_ERR;
                            err      <= 1'b1;
                            err_code <= ERR_ILLEGAL;
                        end else if (cmd_op == OP_DIV
                                     && rb_data == '0) begin
                            state    <= S_ERR;
                            err      <= 1'b1;
                            err_code <= ERR_DIV0;
                        end else begin
                            state     <= S_ISSUE;
                            alu_latch <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    // An update wins over a timeout in the same cycle
                    if (alu_update) begin
                        carry_flag <= alu_carry;
                        alu_latch  <= 1'b0;
                        done       <= 1'b1;
                        state      <= S_DONE;
                    end else if (cnt == CNT_LAST) begin
                        alu_latch <= 1'b0;
                        err       <= 1'b1;
                        err_code  <= ERR_TIMEOUT;
                        state     <= S_ERR;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_DONE:  state <= S_IDLE;
                S_ERR:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural
// 8-bit ALU stub answering on the latch/update interface.
module tb_alu_issue_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_op;
    logic [1:0] cmd_src_a;
    logic [1:0] cmd_src_b;
    logic [1:0] cmd_dst;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;
    logic [1:0] rd_addr;
    logic [7:0] rd_data;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [3:0] alu_sel;
    logic       alu_latch;
    logic [7:0] alu_out;
    logic       alu_carry;
    logic       alu_update;
    logic       carry_flag;
    logic       done;
    logic       err;
    logic [1:0] err_code;

    logic       hold_upd;
    logic [8:0] res;
    logic [15:0] prod;
    int         errors = 0;
    int         checks = 0;
    int         n;

    always #5 clk = ~clk;

    alu_issue_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_src_a  (cmd_src_a),
        .cmd_src_b  (cmd_src_b),
        .cmd_dst    (cmd_dst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_latch  (alu_latch),
        .alu_out    (alu_out),
        .alu_carry  (alu_carry),
        .alu_update (alu_update),
        .carry_flag (carry_flag),
        .done       (done),
        .err        (err),
        .err_code   (err_code)
    );

    // Behavioural ALU: bit 8 of the result is the carry
    always_comb begin
        res  = '0;
        prod = '0;
        case (alu_sel)
            4'd0: res = {1'b0, alu_a} + {1'b0, alu_b};
            4'd1: res = {1'b0, alu_a} - {1'b0, alu_b};
            4'd2: begin
                prod = alu_a * alu_b;
                res  = prod[8:0];
            end
            4'd3: res = (alu_b != 0) ? {1'b0, alu_a / alu_b} : 9'd0;
            4'd4: res = {alu_a, 1'b0};
            4'd5: res = {alu_a[0], 1'b0, alu_a[7:1]};
            4'd6: begin
                prod = alu_a * alu_a;
                res  = prod[8:0];
            end
            4'd7: begin
                prod = alu_b * alu_b;
                res  = prod[8:0];
            end
            default: res = '0;
        endcase
    end

    assign alu_out    = alu_latch ? res[7:0] : 8'h00;
    assign alu_carry  = alu_latch ? res[8] : 1'b0;
    assign alu_update = alu_latch && !hold_upd;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic host_wr(input logic [1:0] a,
                           input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic reg_chk(input string tag,
                           input logic [1:0] a,
                           input logic [7:0] exp);
        rd_addr = a;
        #1;
        check(tag, {24'd0, rd_data}, {24'd0, exp});
    endtask

    // Offers a command for one edge; returns in the cycle after accept
    task automatic send_cmd(input logic [3:0] op,
                            input logic [1:0] sa,
                            input logic [1:0] sb,
                            input logic [1:0] d);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_src_a = sa;
        cmd_src_b = sb;
        cmd_dst   = d;
        @(negedge clk);
        cmd_valid = 1'b0;
        wr_en     = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 16 && !cmd_ready; i++)
            @(negedge clk);
        check(tag, {31'd0, cmd_ready}, 32'd1);
    endtask

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_src_a = '0;
        cmd_src_b = '0;
        cmd_dst   = '0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        rd_addr   = '0;
        hold_upd  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_latch", {31'd0, alu_latch}, 32'd0);
        check("rst_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_code", {30'd0, err_code}, 32'd0);
        check("rst_carry", {31'd0, carry_flag}, 32'd0);
        check("rst_alua", {24'd0, alu_a}, 32'd0);
        reg_chk("rst_r0", 2'd0, 8'h00);
        reset = 1'b0;
        @(negedge clk);

        // Basic add, plus a host write ignored during ISSUE
        host_wr(2'd0, 8'h05);
        host_wr(2'd1, 8'h03);
        send_cmd(4'd0, 2'd0, 2'd1, 2'd2);
        check("add_latch", {31'd0, alu_latch}, 32'd1);
        check("add_a", {24'd0, alu_a}, 32'h05);
        check("add_b", {24'd0, alu_b}, 32'h03);
        check("add_sel", {28'd0, alu_sel}, 32'd0);
        check("add_busy", {31'd0, cmd_ready}, 32'd0);
        check("add_nodone", {31'd0, done}, 32'd0);
        wr_en   = 1'b1;
        wr_addr = 2'd0;
        wr_data = 8'hAA;
        @(negedge clk);
        wr_en = 1'b0;
        check("add_done", {31'd0, done}, 32'd1);
        check("add_unlatch", {31'd0, alu_latch}, 32'd0);
        check("add_carry", {31'd0, carry_flag}, 32'd0);
        reg_chk("add_r2", 2'd2, 8'h08);
        reg_chk("busy_wr_ignored", 2'd0, 8'h05);
        @(negedge clk);
        check("add_done_pulse", {31'd0, done}, 32'd0);
        check("add_ready", {31'd0, cmd_ready}, 32'd1);

        // Carry out of add, then multiply overflow into bit 8
        host_wr(2'd0, 8'hF0);
        host_wr(2'd1, 8'h20);
        send_cmd(4'd0, 2'd0, 2'd1, 2'd3);
        @(negedge clk);
        reg_chk("carry_r3", 2'd3, 8'h10);
        check("carry_flag", {31'd0, carry_flag}, 32'd1);
        wait_idle("carry_idle");
        send_cmd(4'd2, 2'd3, 2'd3, 2'd0);
        check("mul_a", {24'd0, alu_a}, 32'h10);
        @(negedge clk);
        reg_chk("mul_r0", 2'd0, 8'h00);
        check("mul_carry", {31'd0, carry_flag}, 32'd1);
        wait_idle("mul_idle");

        // Divide by zero is rejected before issue
        host_wr(2'd0, 8'h40);
        host_wr(2'd1, 8'h00);
        send_cmd(4'd3, 2'd0, 2'd1, 2'd2);
        check("div0_latch", {31'd0, alu_latch}, 32'd0);
        check("div0_err", {31'd0, err}, 32'd1);
        check("div0_code", {30'd0, err_code}, 32'd2);
        check("div0_busy", {31'd0, cmd_ready}, 32'd0);
        @(negedge clk);
        check("div0_err_pulse", {31'd0, err}, 32'd0);
        check("div0_code_hold", {30'd0, err_code}, 32'd2);
        check("div0_ready", {31'd0, cmd_ready}, 32'd1);
        check("div0_carry", {31'd0, carry_flag}, 32'd1);
        reg_chk("div0_r2", 2'd2, 8'h08);

        // Illegal opcode, then a good SUB clears the code
        send_cmd(4'b1001, 2'd0, 2'd1, 2'd2);
        check("ill_latch", {31'd0, alu_latch}, 32'd0);
        check("ill_err", {31'd0, err}, 32'd1);
        check("ill_code", {30'd0, err_code}, 32'd1);
        wait_idle("ill_idle");
        host_wr(2'd0, 8'h05);
        host_wr(2'd1, 8'h03);
        wr_en   = 1'b1;
        wr_addr = 2'd0;
        wr_data = 8'h77;
        send_cmd(4'd1, 2'd0, 2'd1, 2'd2);
        check("sub_code_clr", {30'd0, err_code}, 32'd0);
        check("sub_prewrite_a", {24'd0, alu_a}, 32'h05);
        @(negedge clk);
        reg_chk("sub_r2", 2'd2, 8'h02);
        check("sub_carry", {31'd0, carry_flag}, 32'd0);
        reg_chk("same_cycle_wr", 2'd0, 8'h77);
        wait_idle("sub_idle");

        // Timeout: ALU never raises update
        hold_upd = 1'b1;
        send_cmd(4'd0, 2'd0, 2'd1, 2'd3);
        n = 0;
        for (int i = 0; i < 12 && alu_latch; i++) begin
            n++;
            @(negedge clk);
        end
        check("to_latch_cycles", n, 32'd4);
        check("to_err", {31'd0, err}, 32'd1);
        check("to_code", {30'd0, err_code}, 32'd3);
        reg_chk("to_r3", 2'd3, 8'h10);
        check("to_carry", {31'd0, carry_flag}, 32'd0);
        hold_upd = 1'b0;
        wait_idle("to_idle");

        // Chained r2 = r2 + r2
        host_wr(2'd2, 8'h04);
        send_cmd(4'd0, 2'd2, 2'd2, 2'd2);
        @(negedge clk);
        reg_chk("chain1_r2", 2'd2, 8'h08);
        wait_idle("chain1_idle");
        send_cmd(4'd0, 2'd2, 2'd2, 2'd2);
        @(negedge clk);
        reg_chk("chain2_r2", 2'd2, 8'h10);
        wait_idle("chain2_idle");

        // Reset in the middle of ISSUE
        send_cmd(4'd0, 2'd2, 2'd2, 2'd2);
        check("rst_pre_latch", {31'd0, alu_latch}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("rst_mid_latch", {31'd0, alu_latch}, 32'd0);
        check("rst_mid_ready", {31'd0, cmd_ready}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int r = 0; r < 4; r++)
            reg_chk("rst_mid_reg", 2'(r), 8'h00);
        check("rst_mid_done", {31'd0, done}, 32'd0);
        check("rst_mid_idle", {31'd0, cmd_ready}, 32'd1);

        $display("Result: errors=%0d of %0d checks",
                 errors, checks);
        $finish;
    end

endmodule
